// File: rtl/enc_pkg.sv
// Shared constants and helpers for the request encoder family.
package enc_pkg;

    localparam int ENC_FIXED = 0;
    localparam int ENC_RR    = 1;
    localparam int ERR_CNT_W = 8;

    // Ceiling log2 for elaboration-time width calculation.
    function automatic int enc_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/enc_onehot_rr_prio_pick.sv
// Combinational priority picker: first set bit at or above start, wrapping at N.
module prio_pick
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         none
);

    logic [2*N-1:0] dbl;
    logic           found;

    // Search the doubled vector inside the window [start, start+N) so the wrap is a plain upward scan.
    always_comb begin
        dbl   = {req, req};
        idx   = '0;
        none  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            if (!found && dbl[i] && (i >= int'(start)) && (i < int'(start) + N)) begin
                found = 1'b1;
                none  = 1'b0;
                idx   = (i >= N) ? W'(i - N) : W'(i);
            end
        end
    end

endmodule

// File: rtl/enc_onehot_rr.sv
// Registered N-to-log2(N) request encoder with handshake, fixed/round-robin
// priority, legality flags and a saturating multi-hot error counter.
module enc_onehot_rr
    import enc_pkg::*;
#(
    parameter int N  = 8,
    parameter int RR = ENC_FIXED,
    localparam int W = (enc_clog2(N) < 1) ? 1 : enc_clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_idx,
    output logic                 out_none,
    output logic                 out_multi,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    logic [W-1:0] ptr;
    logic [W-1:0] start;
    logic [W-1:0] pick_idx;
    logic         pick_none;
    logic         multi;
    logic         accept;

    function automatic logic is_multi(input logic [N-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) c = c + 1;
        end
        return c > 1;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign start    = (RR == ENC_RR) ? ptr : '0;
    assign multi    = is_multi(in_req);

    prio_pick #(.N(N), .W(W)) u_pick (
        .req   (in_req),
        .start (start),
        .idx   (pick_idx),
        .none  (pick_none)
    );

    // Stage boundary: output register loads on accept, empties on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_none  <= 1'b0;
            out_multi <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_idx   <= pick_none ? '0 : pick_idx;
            out_none  <= pick_none;
            out_multi <= multi;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the winner of each nonzero accepted vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if ((RR == ENC_RR) && accept && !pick_none) begin
            ptr <= (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);
        end
    end

    // Saturating multi-hot counter; clear wins over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (accept && multi) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule

// File: tb/tb_enc_onehot_rr.sv
// Bench for enc_onehot_rr: fixed N=8, round-robin N=8 and round-robin N=5
// instances share one handshake and are checked against a behavioural model.
module tb_enc_onehot_rr;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_req;
    logic       out_ready;
    logic       err_clr;

    logic       o_rdy   [3];
    logic       o_valid [3];
    logic [2:0] o_idx   [3];
    logic       o_none  [3];
    logic       o_multi [3];
    logic [7:0] o_err   [3];

    int n_checks;
    int n_errors;

    // reference model state, one slot per instance
    int nn [3] = '{8, 8, 5};
    int rr [3] = '{0, 1, 1};
    int m_valid;
    int m_idx   [3];
    int m_none  [3];
    int m_multi [3];
    int m_ptr   [3];
    int m_err   [3];

    enc_onehot_rr #(.N(8), .RR(0)) u_fix8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[0]),
        .in_req(in_req), .out_valid(o_valid[0]), .out_ready(out_ready),
        .out_idx(o_idx[0]), .out_none(o_none[0]), .out_multi(o_multi[0]),
        .err_cnt(o_err[0]), .err_clr(err_clr)
    );

    enc_onehot_rr #(.N(8), .RR(1)) u_rr8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[1]),
        .in_req(in_req), .out_valid(o_valid[1]), .out_ready(out_ready),
        .out_idx(o_idx[1]), .out_none(o_none[1]), .out_multi(o_multi[1]),
        .err_cnt(o_err[1]), .err_clr(err_clr)
    );

    enc_onehot_rr #(.N(5), .RR(1)) u_rr5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[2]),
        .in_req(in_req[4:0]), .out_valid(o_valid[2]), .out_ready(out_ready),
        .out_idx(o_idx[2]), .out_none(o_none[2]), .out_multi(o_multi[2]),
        .err_cnt(o_err[2]), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // first set bit scanning upward from start, wrapping modulo n
    function automatic int ref_pick(input logic [7:0] r, input int n, input int start);
        for (int k = 0; k < n; k++) begin
            if (r[(start + k) % n]) return (start + k) % n;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        for (int i = 0; i < 3; i++) begin
            m_idx[i] = 0; m_none[i] = 0; m_multi[i] = 0; m_ptr[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.valid%0d", tag, i), o_valid[i], m_valid);
            chk($sformatf("%s.idx%0d",   tag, i), o_idx[i],   m_idx[i]);
            chk($sformatf("%s.none%0d",  tag, i), o_none[i],  m_none[i]);
            chk($sformatf("%s.multi%0d", tag, i), o_multi[i], m_multi[i]);
            chk($sformatf("%s.err%0d",   tag, i), o_err[i],   m_err[i]);
        end
    endtask

    // one clock: entered and left at posedge+1
    task automatic cycle(input string tag, input logic v, input logic [7:0] req,
                         input logic ordy, input logic clr);
        int   exp_rdy;
        int   acc;
        int   sel;
        logic [7:0] r;
        logic [7:0] msk;
        in_valid  = v;
        in_req    = req;
        out_ready = ordy;
        err_clr   = clr;
        #1;
        exp_rdy = (m_valid == 0 || ordy) ? 1 : 0;
        for (int i = 0; i < 3; i++) chk($sformatf("%s.in_ready%0d", tag, i), o_rdy[i], exp_rdy);
        acc = (v && exp_rdy) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            msk = 8'((1 << nn[i]) - 1);
            r   = req & msk;
            if (acc != 0) begin
                sel        = ref_pick(r, nn[i], rr[i] != 0 ? m_ptr[i] : 0);
                m_none[i]  = (r == 0) ? 1 : 0;
                m_multi[i] = ($countones(r) > 1) ? 1 : 0;
                m_idx[i]   = (r == 0) ? 0 : sel;
                if (rr[i] != 0 && r != 0) m_ptr[i] = (sel + 1) % nn[i];
            end
            if (clr) m_err[i] = 0;
            else if (acc != 0 && $countones(r) > 1 && m_err[i] < 255) m_err[i]++;
        end
        if (acc != 0) m_valid = 1;
        else if (ordy) m_valid = 0;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [7:0] rq;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_req    = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        for (int i = 0; i < 3; i++) chk($sformatf("reset.in_ready%0d", i), o_rdy[i], 1);
        rst_n = 1'b1;

        // one-hot walk, back to back
        for (int b = 0; b < 8; b++) cycle("onehot", 1'b1, 8'(1 << b), 1'b1, 1'b0);

        // multi-hot then all-zero
        cycle("multi28", 1'b1, 8'h28, 1'b1, 1'b0);
        cycle("zero",    1'b1, 8'h00, 1'b1, 1'b0);

        // round-robin sweep with all requests asserted
        for (int k = 0; k < 10; k++) cycle("rr_ff", 1'b1, 8'hFF, 1'b1, 1'b0);

        // steer RR8 pointer to 6, then a wrapping request
        cycle("rr_p6",  1'b1, 8'h20, 1'b1, 1'b0);
        cycle("rr_05",  1'b1, 8'h05, 1'b1, 1'b0);
        cycle("rr_chk", 1'b1, 8'h06, 1'b1, 1'b0);

        // steer RR5 pointer to 4, then bits 0 and 4
        cycle("n5_p4", 1'b1, 8'h08, 1'b1, 1'b0);
        cycle("n5_11", 1'b1, 8'h11, 1'b1, 1'b0);
        cycle("n5_wr", 1'b1, 8'h1F, 1'b1, 1'b0);

        // backpressure, then simultaneous drain and load
        cycle("bp_load", 1'b1, 8'h04, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle("bp_hold", 1'b1, 8'h02, 1'b0, 1'b0);
        cycle("bp_swap", 1'b1, 8'h02, 1'b1, 1'b0);
        cycle("bp_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // saturation and clear priority
        for (int k = 0; k < 300; k++) cycle("sat", 1'b1, 8'hFF, 1'b1, 1'b0);
        cycle("clr_acc", 1'b1, 8'hFF, 1'b1, 1'b1);
        cycle("post_clr", 1'b1, 8'h03, 1'b1, 1'b0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0:       rq = 8'h00;
                1:       rq = 8'(1 << $urandom_range(0, 7));
                default: rq = 8'($urandom);
            endcase
            cycle("rand", 1'($urandom), rq, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 15) == 0));
        end

        // asynchronous reset while stalled
        cycle("rst_load", 1'b1, 8'h18, 1'b0, 1'b0);
        cycle("rst_hold", 1'b0, 8'h18, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("post_rst", 1'b0, 8'h00, 1'b0, 1'b0);
        cycle("post_rst_acc", 1'b1, 8'h40, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/enc_onehot_rr.md
# enc_onehot_rr

Parametrised, registered N-to-log2(N) request encoder with valid/ready handshake, fixed-priority or round-robin selection, and input-legality flags. It is the successor to our combinational 8-to-3 one-hot encoder. It sits between request producers and arbitration/steering logic that needs a binary index per accepted request vector. Malformed vectors are reported instead of leaving the output stale.

## Interface
- `N`, default 8: request vector width; legal range 2..256, need not be a power of two.
- `RR`, default 0: 0 = fixed priority (lowest index wins); 1 = round-robin priority.
- `W`, localparam = max(1, clog2(N)): index width.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  request vector present.
- `in_ready`  out  1  block can accept a vector this cycle.
- `in_req`  in  N  request vector.
- `out_valid`  out  1  encoded result held in the output register.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out_idx`  out  W  encoded index of the selected bit.
- `out_none`  out  1  accepted vector was all-zero.
- `out_multi`  out  1  accepted vector had more than one bit set.
- `err_cnt`  out  8  saturating count of accepted multi-hot vectors.
- `err_clr`  in  1  synchronous clear of `err_cnt`.

## Operation
- Accept when `in_valid && in_ready`. `in_ready = !out_valid || out_ready` (single-entry output register, combinational pass-through of ready).
- Selection when `RR=0`: the lowest set bit of `in_req` wins. A one-hot bit i gives `out_idx = i`, identical to the legacy 8-to-3 mapping.
- Selection when `RR=1`: search starts at pointer `ptr` (W bits) and proceeds upward, wrapping from N-1 to 0. The first set bit wins.
- Pointer update (`RR=1` only): on acceptance of a nonzero vector, `ptr <= (idx == N-1) ? 0 : idx+1`. The pointer is unchanged on zero vectors and when not accepting.
- Flags, registered with the index:
  - `out_none = (in_req == 0)`; `out_idx = 0` in that case.
  - `out_multi = popcount(in_req) > 1`. The index is still produced by the selection rule.
- `err_cnt`: increments by 1 on each accepted vector with `out_multi` set, and saturates at 255.
  - `err_clr` has priority over an increment in the same cycle; the result is 0.
- Output register holds `out_idx`/flags stable while `out_valid && !out_ready`. The producer must hold `in_req` stable until accepted.

## Timing
- Latency: 1 cycle. A vector accepted at edge k appears on `out_*` after edge k, with `out_valid=1`.
- Throughput: 1 vector/cycle when `out_ready` stays high.
- `out_valid` update at each edge:
  - Accept this cycle: set to 1.
  - `out_ready` without accept: clear to 0.
  - Simultaneous drain and accept: the new result replaces the old one; `out_valid` stays 1.
- Reset values (asserted any time, including mid-transfer): `out_valid=0`, `out_idx=0`, `out_none=0`, `out_multi=0`, `ptr=0`, `err_cnt=0`.
  - Any in-flight result is discarded.
  - `in_ready=1` in the first cycle after release.
- No combinational path from `in_req` to any output. The only combinational path is `out_ready` -> `in_ready`.

## Structure
- Shared package `enc_pkg`:
  - `ENC_FIXED`/`ENC_RR` mode constants.
  - Saturating-counter width constant `ERR_CNT_W = 8`.
  - Function `enc_clog2`.
- Sub-module `prio_pick`: purely combinational. Inputs are `req[N-1:0]` and `start[W-1:0]`; outputs are `idx` and `none`.
  - Implemented as a double-width masked search, so the wrap is explicit.
  - Fixed mode ties `start` to 0.
- Top level contains the handshake, output register, pointer, popcount/multi detect and error counter.

## Test plan
- Fixed mode, N=8: accept one-hot vectors 0x01..0x80 back-to-back with `out_ready=1` -> `out_idx` 0..7 one cycle later; `out_none=0`, `out_multi=0`.
- Fixed mode: accept `0x28` -> `out_idx=3`, `out_multi=1`, `err_cnt=1`. Accept `0x00` -> `out_none=1`, `out_idx=0`, `err_cnt` unchanged.
- RR mode, N=8, `in_req=0xFF` held for 10 accepts -> `out_idx` = 0,1,…,7,0,1. With `ptr=6`, `in_req=0x05` -> `out_idx=0`, next `ptr=1`.
- Backpressure: `out_ready=0` for 3 cycles after one accept -> `in_ready=0`, `out_idx` stable. Raise `out_ready` with `in_valid=1` -> old result consumed and new one loaded in the same edge.
- Counter edges:
  - 300 multi-hot accepts -> `err_cnt=255`.
  - `err_clr` coincident with a multi-hot accept -> `err_cnt=0`.
- Non-power-of-two N=5, RR: `in_req=0x11` with `ptr=4` -> `out_idx=4`, `ptr` wraps to 0. Async reset mid-backpressure -> all outputs 0 immediately, `in_ready=1` after release.
